ra_2r1w_32x32_bist: RTL

- Self-contained access initiator/checker that drives the read and write ports of a 2R1W 32-entry x 32-bit registered array wrapper.
- Runs a two-pass write/read-compare test and reports pass/fail, an error count and the first failing address/port.
- Sits between a control register (start/status) and the array wrapper. It is the initiator for the array's slave-side port set.

---
 rtl/ra_2r1w_32x32_bist_pkg.sv | 32 +++
 rtl/ra_bist_cmp_pipe.sv | 70 +++++++
 rtl/ra_2r1w_32x32_bist.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/ra_2r1w_32x32_bist_pkg.sv
// Shared constants, FSM encoding, read-tag type and the BIST data function
// for the 2R1W 32x32 array self-test.
package ra_2r1w_32x32_bist_pkg;

  localparam int unsigned DEPTH = 32;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned AW    = 5;

  localparam logic [0:WIDTH-1] BG_DEFAULT = 32'hA5A5_5A5A;
  localparam logic [0:AW-1]    LAST_ADR   = AW'(DEPTH - 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_WRITE = 3'd1;
  localparam logic [2:0] ST_GAP   = 3'd2;
  localparam logic [2:0] ST_READ  = 3'd3;
  localparam logic [2:0] ST_DRAIN = 3'd4;
  localparam logic [2:0] ST_FIN   = 3'd5;

  // One issued read: port 0 address (port 1 is its complement) and pass tag.
  typedef struct packed {
    logic            vld;
    logic [0:AW-1]   adr;
    logic            pass;
  } rd_tag_t;

  function automatic logic [0:WIDTH-1] bist_data(input logic [0:WIDTH-1] bg,
                                                 input logic [0:AW-1]    adr,
                                                 input logic             pass);
    return (pass ? ~bg : bg) ^ {{(WIDTH - AW){1'b0}}, adr};
  endfunction

endpackage

// File: rtl/ra_bist_cmp_pipe.sv
// Read-latency tracking pipe, dual-port comparators, saturating error counter
// and first-failure capture for the array BIST.
module ra_bist_cmp_pipe
  import ra_2r1w_32x32_bist_pkg::*;
#(
  parameter int unsigned      RD_LAT = 2,
  parameter logic [0:WIDTH-1] BG     = BG_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  rd_tag_t          iss_i,
  input  logic [0:WIDTH-1] rd_dat_0_i,
  input  logic [0:WIDTH-1] rd_dat_1_i,
  output logic             fail_o,
  output logic [0:7]       err_cnt_o,
  output logic [0:AW-1]    fail_adr_o,
  output logic             fail_port_o
);

  rd_tag_t       pipe_q [RD_LAT];
  rd_tag_t       tail;
  logic          mis_0;
  logic          mis_1;
  logic [0:8]    err_sum;
  logic          fail_q;
  logic [0:7]    err_cnt_q;
  logic [0:AW-1] fail_adr_q;
  logic          fail_port_q;

  assign tail    = pipe_q[RD_LAT-1];
  assign mis_0   = tail.vld && (rd_dat_0_i != bist_data(BG, tail.adr, tail.pass));
  assign mis_1   = tail.vld && (rd_dat_1_i != bist_data(BG, ~tail.adr, tail.pass));
  assign err_sum = {1'b0, err_cnt_q} + {8'b0, mis_0} + {8'b0, mis_1};

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: every stage is reset, not just the data path; a stale valid left
      // over from an aborted test would otherwise raise a bogus miscompare.
      for (int i = 0; i < int'(RD_LAT); i++) pipe_q[i] <= '0;
      fail_q      <= 1'b0;
      err_cnt_q   <= '0;
      fail_adr_q  <= '0;
      fail_port_q <= 1'b0;
    end else begin
      pipe_q[0] <= iss_i;
      for (int i = 1; i < int'(RD_LAT); i++) pipe_q[i] <= pipe_q[i-1];
      if (clr_i) begin
        fail_q      <= 1'b0;
        err_cnt_q   <= '0;
        fail_adr_q  <= '0;
        fail_port_q <= 1'b0;
      end else begin
        err_cnt_q <= err_sum[0] ? 8'hFF : err_sum[1:8];
        // Port 0 wins a same-cycle tie for the first-failure record.
        if ((mis_0 || mis_1) && !fail_q) begin
          fail_adr_q  <= mis_0 ? tail.adr : ~tail.adr;
          fail_port_q <= !mis_0;
        end
        fail_q <= fail_q || mis_0 || mis_1;
      end
    end
  end

  assign fail_o      = fail_q;
  assign err_cnt_o   = err_cnt_q;
  assign fail_adr_o  = fail_adr_q;
  assign fail_port_o = fail_port_q;

endmodule

// File: rtl/ra_2r1w_32x32_bist.sv
// Two-pass write/read-compare self-test initiator for a 2R1W 32x32 registered
// array; every array-facing and status output comes straight from a flop.
module ra_2r1w_32x32_bist
  import ra_2r1w_32x32_bist_pkg::*;
#(
  parameter int unsigned      RD_LAT = 2,
  parameter logic [0:WIDTH-1] BG     = BG_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             fail,
  output logic [0:7]       err_cnt,
  output logic [0:4]       fail_adr,
  output logic             fail_port,
  output logic             rd_enb_0,
  output logic [0:4]       rd_adr_0,
  input  logic [0:31]      rd_dat_0,
  output logic             rd_enb_1,
  output logic [0:4]       rd_adr_1,
  input  logic [0:31]      rd_dat_1,
  output logic             wr_enb_0,
  output logic [0:4]       wr_adr_0,
  output logic [0:31]      wr_dat_0
);

  localparam logic [1:0] DRAIN_LAST = 2'(RD_LAT - 1);

  logic [2:0]       state_q, state_d;
  logic [0:AW-1]    adr_q, adr_d;
  logic             pass_q, pass_d;
  logic [1:0]       drain_q, drain_d;
  logic             busy_q, done_q;
  logic             rd_enb_q, wr_enb_q;
  logic [0:AW-1]    rd_adr_0_q, rd_adr_1_q, wr_adr_q;
  logic [0:WIDTH-1] wr_dat_q;
  logic             accept;
  rd_tag_t          iss;

  assign accept = start && (state_q == ST_IDLE || state_q == ST_FIN);

  always_comb begin
    // NOTE: each _d starts at its hold value so no branch leaves it
    // unassigned, which would otherwise infer a latch.
    state_d = state_q;
    adr_d   = adr_q;
    pass_d  = pass_q;
    drain_d = drain_q;
    case (state_q)
      ST_IDLE, ST_FIN: begin
        if (accept) begin
          state_d = ST_WRITE;
          adr_d   = '0;
          pass_d  = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WRITE: begin
        if (adr_q == LAST_ADR) begin
          state_d = ST_GAP;
          adr_d   = '0;
        end else begin
          adr_d = adr_q + AW'(1);
        end
      end
      ST_GAP: state_d = ST_READ;
      ST_READ: begin
        if (adr_q == LAST_ADR) begin
          state_d = ST_DRAIN;
          adr_d   = '0;
          drain_d = '0;
        end else begin
          adr_d = adr_q + AW'(1);
        end
      end
      ST_DRAIN: begin
        if (drain_q == DRAIN_LAST) begin
          drain_d = '0;
          if (!pass_q) begin
            state_d = ST_WRITE;
            pass_d  = 1'b1;
          end else begin
            state_d = ST_FIN;
          end
        end else begin
          drain_d = drain_q + 2'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      adr_q      <= '0;
      pass_q     <= 1'b0;
      drain_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_enb_q   <= 1'b0;
      rd_adr_0_q <= '0;
      rd_adr_1_q <= '0;
      wr_enb_q   <= 1'b0;
      wr_adr_q   <= '0;
      wr_dat_q   <= '0;
    end else begin
      state_q    <= state_d;
      adr_q      <= adr_d;
      pass_q     <= pass_d;
      drain_q    <= drain_d;
      busy_q     <= (state_d != ST_IDLE) && (state_d != ST_FIN);
      done_q     <= (state_d == ST_FIN) || (done_q && !accept);
      rd_enb_q   <= (state_d == ST_READ);
      rd_adr_0_q <= (state_d == ST_READ) ? adr_d : '0;
      rd_adr_1_q <= (state_d == ST_READ) ? ~adr_d : '0;
      wr_enb_q   <= (state_d == ST_WRITE);
      wr_adr_q   <= (state_d == ST_WRITE) ? adr_d : '0;
      wr_dat_q   <= (state_d == ST_WRITE) ? bist_data(BG, adr_d, pass_d) : '0;
    end
  end

  assign iss = '{vld: rd_enb_q, adr: rd_adr_0_q, pass: pass_q};

  ra_bist_cmp_pipe #(
    .RD_LAT (RD_LAT),
    .BG     (BG)
  ) u_cmp (
    .clk         (clk),
    .reset       (reset),
    .clr_i       (accept),
    .iss_i       (iss),
    .rd_dat_0_i  (rd_dat_0),
    .rd_dat_1_i  (rd_dat_1),
    .fail_o      (fail),
    .err_cnt_o   (err_cnt),
    .fail_adr_o  (fail_adr),
    .fail_port_o (fail_port)
  );

  assign busy     = busy_q;
  assign done     = done_q;
  assign rd_enb_0 = rd_enb_q;
  assign rd_adr_0 = rd_adr_0_q;
  assign rd_enb_1 = rd_enb_q;
  assign rd_adr_1 = rd_adr_1_q;
  assign wr_enb_0 = wr_enb_q;
  assign wr_adr_0 = wr_adr_q;
  assign wr_dat_0 = wr_dat_q;

endmodule
